// File: rtl/pifo_reg_store_if.sv
`default_nettype none
// ============================================================================
// Module   : pifo_reg_store_if
// Purpose  : Bundles the request, tree-loop and status signals of the PIFO
//            register-file storage stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pifo_reg_store_if #(
  parameter int REG_WIDTH  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 8
);

  logic                            insert;
  logic [DATA_WIDTH-1:0]           insert_data;
  logic                            remove;
  logic [DATA_WIDTH-1:0]           tree_max;
  logic [IDX_WIDTH-1:0]            tree_idx;
  logic                            tree_vld;
  logic [REG_WIDTH*DATA_WIDTH-1:0] data_out;
  logic [REG_WIDTH*IDX_WIDTH-1:0]  idx_out;
  logic [REG_WIDTH-1:0]            vld_out;
  logic                            deq_valid;
  logic [DATA_WIDTH-1:0]           deq_data;
  logic [IDX_WIDTH-1:0]            deq_idx;
  logic [IDX_WIDTH:0]              count;
  logic                            full;
  logic                            empty;
  logic                            err_ovf;
  logic                            err_udf;

  // Requester plus reduction-tree side of the loop.
  modport master (
    output insert, insert_data, remove, tree_max, tree_idx, tree_vld,
    input  data_out, idx_out, vld_out, deq_valid, deq_data, deq_idx,
    input  count, full, empty, err_ovf, err_udf
  );

  modport slave (
    input  insert, insert_data, remove, tree_max, tree_idx, tree_vld,
    output data_out, idx_out, vld_out, deq_valid, deq_data, deq_idx,
    output count, full, empty, err_ovf, err_udf
  );

endinterface
`default_nettype wire

// File: rtl/pifo_reg_store.sv
`default_nettype none
// ============================================================================
// Module   : pifo_reg_store
// Purpose  : Register-file slot store of the register-based PIFO; exposes slot
//            ranks to an external max tree and dequeues the tree's winner.
// Revision : 1.0 - initial release
// ============================================================================
module pifo_reg_store #(
  parameter int REG_WIDTH  = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  pifo_reg_store_if.slave  bus
);

  localparam logic [IDX_WIDTH:0] c_count_one = (IDX_WIDTH+1)'(1);

  logic [REG_WIDTH-1:0]  r_vld;
  logic [DATA_WIDTH-1:0] r_data [REG_WIDTH];
  logic [IDX_WIDTH:0]    r_count;
  logic                  r_deq_valid;
  logic [DATA_WIDTH-1:0] r_deq_data;
  logic [IDX_WIDTH-1:0]  r_deq_idx;
  logic                  r_err_ovf;
  logic                  r_err_udf;

  logic [REG_WIDTH-1:0]  w_vld_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt [REG_WIDTH];
  logic [IDX_WIDTH:0]    w_count_nxt;
  logic [IDX_WIDTH-1:0]  w_free_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rm_ok;
  logic                  w_ins_new;
  logic                  w_ins_rep;
  logic                  w_ins_acc;
  logic                  w_ins_drop;
  logic                  w_rm_bad;

  assign w_full  = &r_vld;
  assign w_empty = ~|r_vld;

  // A remove only counts when the tree points at a slot that is really occupied.
  assign w_rm_ok    = bus.remove & bus.tree_vld & r_vld[bus.tree_idx];
  assign w_ins_new  = bus.insert & ~w_full;
  assign w_ins_rep  = bus.insert & w_full & w_rm_ok;
  assign w_ins_acc  = w_ins_new | w_ins_rep;
  assign w_ins_drop = bus.insert & w_full & ~w_rm_ok;
  assign w_rm_bad   = bus.remove & ~w_rm_ok;

  // Lowest free slot, taken from the pre-remove occupancy.
  always_comb begin
    w_free_idx = '0;
    for (int i = REG_WIDTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) begin
        w_free_idx = IDX_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_vld_nxt = r_vld;
    for (int i = 0; i < REG_WIDTH; i++) begin
      w_data_nxt[i] = r_data[i];
    end
    if (w_rm_ok) begin
      w_vld_nxt[bus.tree_idx] = 1'b0;
    end
    if (w_ins_new) begin
      w_vld_nxt[w_free_idx]  = 1'b1;
      w_data_nxt[w_free_idx] = bus.insert_data;
    end
    // When full, the slot being popped is refilled in the same edge.
    if (w_ins_rep) begin
      w_vld_nxt[bus.tree_idx]  = 1'b1;
      w_data_nxt[bus.tree_idx] = bus.insert_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_ins_acc && !w_rm_ok) begin
      w_count_nxt = r_count + c_count_one;
    end else if (!w_ins_acc && w_rm_ok) begin
      w_count_nxt = r_count - c_count_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_count <= '0;
      for (int i = 0; i < REG_WIDTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld   <= w_vld_nxt;
      r_count <= w_count_nxt;
      for (int i = 0; i < REG_WIDTH; i++) begin
        r_data[i] <= w_data_nxt[i];
      end
    end
  end

  // deq_data/deq_idx hold their last value when no dequeue happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deq_valid <= 1'b0;
      r_deq_data  <= '0;
      r_deq_idx   <= '0;
      r_err_ovf   <= 1'b0;
      r_err_udf   <= 1'b0;
    end else begin
      r_deq_valid <= w_rm_ok;
      r_err_ovf   <= w_ins_drop;
      r_err_udf   <= w_rm_bad;
      if (w_rm_ok) begin
        r_deq_data <= bus.tree_max;
        r_deq_idx  <= bus.tree_idx;
      end
    end
  end

  generate
    for (genvar i = 0; i < REG_WIDTH; i++) begin : g_slot
      assign bus.data_out[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] = r_data[i];
      assign bus.idx_out[i*IDX_WIDTH +: IDX_WIDTH]          = IDX_WIDTH'(i);
    end
  endgenerate

  assign bus.vld_out   = r_vld;
  assign bus.count     = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.deq_valid = r_deq_valid;
  assign bus.deq_data  = r_deq_data;
  assign bus.deq_idx   = r_deq_idx;
  assign bus.err_ovf   = r_err_ovf;
  assign bus.err_udf   = r_err_udf;

endmodule
`default_nettype wire

// File: tb/tb_pifo_reg_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_pifo_reg_store
// Purpose  : Closes the PIFO store loop through a pairwise-max tree and checks
//            it against a slot-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pifo_reg_store;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  int   sv [4];
  bit   sb [4];

  pifo_reg_store_if #(.REG_WIDTH(4), .IDX_WIDTH(2), .DATA_WIDTH(8)) bus ();

  pifo_reg_store #(.REG_WIDTH(4), .IDX_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-level max tree; on equal ranks the higher slot index wins.
  logic [7:0] m01, m23, d0, d1, d2, d3;
  logic [1:0] i01, i23;
  logic       v01, v23;
  always_comb begin
    d0 = bus.data_out[7:0];
    d1 = bus.data_out[15:8];
    d2 = bus.data_out[23:16];
    d3 = bus.data_out[31:24];
    if (bus.vld_out[1] && (!bus.vld_out[0] || d1 >= d0)) begin
      m01 = d1; i01 = 2'd1;
    end else begin
      m01 = d0; i01 = 2'd0;
    end
    if (bus.vld_out[3] && (!bus.vld_out[2] || d3 >= d2)) begin
      m23 = d3; i23 = 2'd3;
    end else begin
      m23 = d2; i23 = 2'd2;
    end
    v01 = bus.vld_out[0] | bus.vld_out[1];
    v23 = bus.vld_out[2] | bus.vld_out[3];
    if (v23 && (!v01 || m23 >= m01)) begin
      bus.tree_max = m23; bus.tree_idx = i23;
    end else begin
      bus.tree_max = m01; bus.tree_idx = i01;
    end
    bus.tree_vld = v01 | v23;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      sv[i] = 0;
      sb[i] = 1'b0;
    end
  endtask

  // One clock of stimulus; the model predicts the outcome from the slot rules.
  task automatic cycle(input bit ins, input logic [7:0] d, input bit rem);
    bit   has, was_full, rm_ok, exp_ovf, exp_udf;
    int   m, f, cnt;
    int   exp_dd, exp_di;
    logic [3:0] ev;
    @(negedge clk);
    bus.insert      = ins;
    bus.insert_data = d;
    bus.remove      = rem;
    has = 1'b0; m = 0; f = -1; was_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (sb[i] && (!has || sv[i] >= sv[m])) begin
        m = i; has = 1'b1;
      end
      if (!sb[i]) begin
        was_full = 1'b0;
        if (f < 0) f = i;
      end
    end
    rm_ok   = rem && has;
    exp_ovf = ins && was_full && !rm_ok;
    exp_udf = rem && !rm_ok;
    exp_dd  = sv[m];
    exp_di  = m;
    if (rm_ok) sb[m] = 1'b0;
    if (ins && !was_full) begin
      sb[f] = 1'b1; sv[f] = int'(d);
    end else if (ins && rm_ok) begin
      sb[m] = 1'b1; sv[m] = int'(d);
    end
    @(posedge clk);
    #1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = sb[i];
      if (sb[i]) begin
        cnt++;
        check($sformatf("slot%0d", i), 32'(bus.data_out[i*8 +: 8]), 32'(sv[i]));
      end
    end
    check("deq_valid", 32'(bus.deq_valid), 32'(rm_ok));
    if (rm_ok) begin
      check("deq_data", 32'(bus.deq_data), 32'(exp_dd));
      check("deq_idx", 32'(bus.deq_idx), 32'(exp_di));
    end
    check("err_ovf", 32'(bus.err_ovf), 32'(exp_ovf));
    check("err_udf", 32'(bus.err_udf), 32'(exp_udf));
    check("vld_out", 32'(bus.vld_out), 32'(ev));
    check("count", 32'(bus.count), 32'(cnt));
    check("full", 32'(bus.full), 32'(cnt == 4));
    check("empty", 32'(bus.empty), 32'(cnt == 0));
    check("count_popcount", 32'(bus.count), 32'($countones(bus.vld_out)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.insert = 1'b0;
    bus.remove = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_5937();
    cycle(1'b1, 8'd5, 1'b0);
    cycle(1'b1, 8'd9, 1'b0);
    cycle(1'b1, 8'd3, 1'b0);
    cycle(1'b1, 8'd7, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_d [4];
    logic [1:0] exp_i [4];
    exp_d[0] = 8'd9; exp_d[1] = 8'd7; exp_d[2] = 8'd5; exp_d[3] = 8'd3;
    exp_i[0] = 2'd1; exp_i[1] = 2'd3; exp_i[2] = 2'd0; exp_i[3] = 2'd2;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.insert = 1'b0;
    bus.insert_data = 8'd0;
    bus.remove = 1'b0;
    model_clear();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_vld", 32'(bus.vld_out), 32'h0);
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_full", 32'(bus.full), 32'h0);
    check("rst_deq_valid", 32'(bus.deq_valid), 32'h0);
    check("rst_deq_data", 32'(bus.deq_data), 32'h0);
    check("rst_err", 32'({bus.err_ovf, bus.err_udf}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Fill, overflow, drain in rank order
    fill_5937();
    check("t2_data", 32'(bus.data_out), 32'h07_03_09_05);
    check("t2_full", 32'(bus.full), 32'h1);
    cycle(1'b1, 8'd1, 1'b0);
    check("t2_ovf", 32'(bus.err_ovf), 32'h1);
    check("t2_unchanged", 32'(bus.data_out), 32'h07_03_09_05);
    cycle(1'b0, 8'd0, 1'b0);
    check("t2_ovf_pulse", 32'(bus.err_ovf), 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 8'd0, 1'b1);
      check($sformatf("t3_deq_data%0d", k), 32'(bus.deq_data), 32'(exp_d[k]));
      check($sformatf("t3_deq_idx%0d", k), 32'(bus.deq_idx), 32'(exp_i[k]));
    end
    check("t3_empty", 32'(bus.empty), 32'h1);
    check("t3_count", 32'(bus.count), 32'h0);

    // Full insert + remove in one cycle replaces the popped slot
    do_reset();
    fill_5937();
    cycle(1'b1, 8'd2, 1'b1);
    check("t4_deq_data", 32'(bus.deq_data), 32'd9);
    check("t4_deq_idx", 32'(bus.deq_idx), 32'd1);
    check("t4_slot1", 32'(bus.data_out[15:8]), 32'd2);
    check("t4_count", 32'(bus.count), 32'd4);
    check("t4_no_ovf", 32'(bus.err_ovf), 32'h0);

    // Underflow and tie-break
    do_reset();
    cycle(1'b0, 8'd0, 1'b1);
    check("t5_udf", 32'(bus.err_udf), 32'h1);
    check("t5_deq_valid", 32'(bus.deq_valid), 32'h0);
    cycle(1'b0, 8'd0, 1'b0);
    check("t5_udf_pulse", 32'(bus.err_udf), 32'h0);
    cycle(1'b1, 8'd4, 1'b0);
    cycle(1'b1, 8'd4, 1'b0);
    cycle(1'b0, 8'd0, 1'b1);
    check("t5_tie_idx", 32'(bus.deq_idx), 32'd1);

    // Asynchronous reset mid-operation
    do_reset();
    cycle(1'b1, 8'd11, 1'b0);
    cycle(1'b1, 8'd22, 1'b0);
    cycle(1'b1, 8'd33, 1'b0);
    @(negedge clk);
    bus.insert = 1'b0;
    bus.remove = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_vld", 32'(bus.vld_out), 32'h0);
    check("t6_async_count", 32'(bus.count), 32'h0);
    check("t6_async_deq", 32'(bus.deq_valid), 32'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'd6, 1'b0);
    check("t6_slot0_vld", 32'(bus.vld_out), 32'h1);
    check("t6_slot0_data", 32'(bus.data_out[7:0]), 32'd6);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 9) < 5, 8'($urandom_range(0, 255)), $urandom_range(0, 9) < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
